// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle control path -- FSM states,
// opcodes, ALUOp codes, alu_control codes and datapath mux selects.
// The ALU consumes the same ALU_* codes that alu_decoder produces.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    // Opcodes understood by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUOp: what the FSM asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alu_control codes, shared with the ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Result mux selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // funct3 values the ALU can execute for R/I-type arithmetic
    function automatic logic funct3_supported(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational translation of ALUOp plus instruction fields
// into the ALU operation code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    // Select the ALU operation; sub only for R-type with bit 30 set
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of a multicycle RISC-V style datapath.
// Datapath selects are Moore decodes of the state; alu_control, imm_src
// and the branch part of pc_write also look at the instruction fields.
// Build option: define CTRL_JAL_EN to support jal; without it opcode
// 1101111 is treated as illegal.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       illegal,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control
);

    state_t     state_q, state_d;
    logic       illegal_q;

    logic       pc_update;
    logic       branch;
    logic       ir_w;
    logic       reg_w;
    logic       mem_w;
    logic [1:0] alu_op;

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = funct3_supported(funct3) ? S_EXECUTER : S_ERROR;
                    OP_ITYPE:  state_d = funct3_supported(funct3) ? S_EXECUTEI : S_ERROR;
                    OP_BRANCH: state_d = S_BEQ;
`ifdef CTRL_JAL_EN
                    OP_JAL:    state_d = S_JAL;
`endif
                    default:   state_d = S_ERROR;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI: state_d = S_ALUWB;
`ifdef CTRL_JAL_EN
            S_JAL:      state_d = S_ALUWB;
`endif
            S_MEMWB,
            S_MEMWRITE,
            S_ALUWB,
            S_BEQ:      state_d = S_FETCH;
            S_ERROR:    state_d = S_ERROR;
            // Unused encodings are treated as a corrupted instruction
            default:    state_d = S_ERROR;
        endcase
    end

    // State register and sticky illegal flag; reset abandons any instruction
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_ERROR);
        end
    end

    // Moore decode of the datapath controls for each state
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_w       = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
`ifdef CTRL_JAL_EN
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Immediate format depends only on the opcode, in every state
    always_comb begin
        case (op)
            OP_LOAD,
            OP_ITYPE:  imm_src = IMM_I;
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_control)
    );

    // Write enables are held off while reset is asserted; zero only matters in BEQ
    assign pc_write  = reset_n & (pc_update | (branch & zero));
    assign ir_write  = reset_n & ir_w;
    assign reg_write = reset_n & reg_w;
    assign mem_write = reset_n & mem_w;
    assign illegal   = illegal_q;

endmodule
